// File: rtl/risk_limit_cache.sv
// Per-client pre-trade risk store: max-to-trade and running total per client.
// Orders are checked and committed in a 2-stage read-modify-write pipeline.
module risk_limit_cache #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    input  logic [A_WIDTH-1:0] cfg_client,
    input  logic [D_WIDTH-1:0] cfg_max,
    input  logic               cfg_clear_acc,
    input  logic               ord_valid,
    output logic               ord_ready,
    input  logic [A_WIDTH-1:0] ord_client,
    input  logic [D_WIDTH-1:0] ord_qty,
    output logic               res_valid,
    output logic               res_accept,
    output logic [A_WIDTH-1:0] res_client,
    output logic [D_WIDTH-1:0] res_accum,
    output logic [D_WIDTH-1:0] res_headroom,
    output logic               busy
);

    localparam int CLIENTS = 2 ** A_WIDTH;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [A_WIDTH-1:0] init_addr_q, init_addr_d;
    logic               init_we;
    logic               run;

    logic [D_WIDTH-1:0] max_mem [CLIENTS];
    logic [D_WIDTH-1:0] acc_mem [CLIENTS];

    logic               s1_valid_q;
    logic [A_WIDTH-1:0] s1_client_q;
    logic [D_WIDTH-1:0] s1_qty_q;
    logic [D_WIDTH-1:0] s1_max_q;
    logic [D_WIDTH-1:0] s1_acc_q;

    logic               res_valid_q;
    logic               res_accept_q;
    logic [A_WIDTH-1:0] res_client_q;
    logic [D_WIDTH-1:0] res_accum_q;
    logic [D_WIDTH-1:0] res_headroom_q;

    logic               take;
    logic               cfg_we;
    logic [D_WIDTH:0]   sum;
    logic               accept;
    logic               acc_we;
    logic               fwd;
    logic [D_WIDTH-1:0] accum_w;
    logic [D_WIDTH-1:0] hr_w;

    // State register and init sweep address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            init_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
        end
    end

    // Next state: sweep every address once, then run
    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        case (state_q)
            INIT: begin
                init_addr_d = init_addr_q + A_WIDTH'(1);
                if (init_addr_q == {A_WIDTH{1'b1}}) begin
                    state_d = RUN;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    // FSM outputs: config takes priority over orders
    always_comb begin
        run       = (state_q == RUN);
        busy      = (state_q == INIT);
        init_we   = (state_q == INIT);
        ord_ready = run && !cfg_valid;
    end

    // S1 datapath: 33-bit add so a carry always rejects
    always_comb begin
        take    = ord_valid && ord_ready;
        cfg_we  = run && cfg_valid;
        sum     = {1'b0, s1_acc_q} + {1'b0, s1_qty_q};
        accept  = !sum[D_WIDTH] && (sum[D_WIDTH-1:0] <= s1_max_q);
        acc_we  = run && s1_valid_q && accept;
        fwd     = acc_we && (s1_client_q == ord_client);
        accum_w = accept ? sum[D_WIDTH-1:0] : s1_acc_q;
        hr_w    = (s1_max_q >= accum_w) ? (s1_max_q - accum_w) : '0;
    end

    // Storage and registered reads; a same-cycle clear beats the S1 commit
    always_ff @(posedge clk) begin
        if (init_we) begin
            max_mem[init_addr_q] <= '0;
            acc_mem[init_addr_q] <= '0;
        end else begin
            if (acc_we) begin
                acc_mem[s1_client_q] <= sum[D_WIDTH-1:0];
            end
            if (cfg_we) begin
                max_mem[cfg_client] <= cfg_max;
                if (cfg_clear_acc) begin
                    acc_mem[cfg_client] <= '0;
                end
            end
        end
        if (take) begin
            s1_max_q <= max_mem[ord_client];
            s1_acc_q <= fwd ? sum[D_WIDTH-1:0] : acc_mem[ord_client];
        end
    end

    // S1 control and order fields; reset drops anything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_client_q <= '0;
            s1_qty_q    <= '0;
        end else begin
            s1_valid_q <= take;
            if (take) begin
                s1_client_q <= ord_client;
                s1_qty_q    <= ord_qty;
            end
        end
    end

    // Registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q    <= 1'b0;
            res_accept_q   <= 1'b0;
            res_client_q   <= '0;
            res_accum_q    <= '0;
            res_headroom_q <= '0;
        end else begin
            res_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                res_accept_q   <= accept;
                res_client_q   <= s1_client_q;
                res_accum_q    <= accum_w;
                res_headroom_q <= hr_w;
            end
        end
    end

    assign res_valid    = res_valid_q;
    assign res_accept   = res_accept_q;
    assign res_client   = res_client_q;
    assign res_accum    = res_accum_q;
    assign res_headroom = res_headroom_q;

endmodule

// File: doc/risk_limit_cache.md
Name: risk_limit_cache

Overview:
- Per-client pre-trade risk store for the order path. Holds a configurable maximum-to-trade and a running accumulated-order total per client ID.
- Each incoming order is checked and, if accepted, committed in a single read-modify-write pipeline at one order per cycle.
- Sits between the order decoder (upstream) and the order sender (downstream). Host configuration uses a separate write port.

Parameters:
D_WIDTH, 32, width of quantities, limits and accumulators
A_WIDTH, 10, client ID width; client count CLIENTS = 2**A_WIDTH (localparam)

Ports:
clk  in  1  single clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  config write strobe (single cycle, no ready)
cfg_client  in  A_WIDTH  client to configure
cfg_max  in  D_WIDTH  new maximum-to-trade
cfg_clear_acc  in  1  with cfg_valid: also zero that client's accumulator
ord_valid  in  1  order request valid
ord_ready  out  1  block can take an order this cycle
ord_client  in  A_WIDTH  order client ID
ord_qty  in  D_WIDTH  order quantity
res_valid  out  1  one-cycle result pulse
res_accept  out  1  1 = order within limit and committed
res_client  out  A_WIDTH  client of the result
res_accum  out  D_WIDTH  accumulator value after this order
res_headroom  out  D_WIDTH  max minus res_accum, floored at 0
busy  out  1  init sweep in progress

Behaviour:
- Storage: two arrays of CLIENTS x D_WIDTH, max_mem and acc_mem, kept separate (no address-offset aliasing). Reads are synchronous (registered).
- Reset (rst_n low, asynchronous):
  - Outputs go to: ord_ready=0, busy=1, res_valid=0, res_accept=0, res_client=0, res_accum=0, res_headroom=0.
  - In-flight orders are discarded with no result. Array contents are not reset directly.
- FSM states INIT and RUN; reset enters INIT.
  - INIT: an address counter writes 0 to max_mem and acc_mem, one address per cycle, from 0 to CLIENTS-1. cfg writes are ignored and ord_ready=0.
  - After address CLIENTS-1 is written, move to RUN, busy=0, ord_ready=1 from the next cycle.
  - A reset during INIT restarts the sweep from address 0.
- RUN handshake:
  - ord_ready = !cfg_valid; config has priority and stalls orders for that cycle.
  - An order is taken when ord_valid && ord_ready.
- Pipeline (latency 2 from handshake to res_valid; throughput 1 per cycle):
  - S0, handshake cycle: read max_mem and acc_mem at ord_client; register client and qty.
  - S1: sum = acc + qty at D_WIDTH+1 bits. accept = (sum[D_WIDTH]==0) && (sum[D_WIDTH-1:0] <= max). If accepted, write acc_mem[client] = sum at end of S1.
  - Results are registered: res_valid pulses one cycle after S1.
  - res_accum = sum if accepted, old acc if rejected.
  - res_headroom = max - res_accum if max >= res_accum, else 0.
- Hazard forwarding: if S0's client equals S1's client and S1 accepts, S0 uses S1's sum instead of the acc_mem read. Back-to-back orders for the same client must accumulate correctly.
- Config write (RUN, cfg_valid):
  - max_mem[cfg_client] = cfg_max.
  - If cfg_clear_acc is set, acc_mem[cfg_client] = 0.
  - If cfg_clear_acc and an S1 accepted write hit the same client in the same cycle, the clear wins (acc=0). The S1 result is still reported with its computed values.
  - An order already in S1 uses the max read at its S0; new limits apply from the next accepted order.
- Overflow: a carry out of sum always rejects; the accumulator never wraps.
- Lowered limit: if acc > max after reconfiguration, all nonzero orders reject with headroom 0. An order with qty=0 accepts only if acc <= max.
- No output backpressure: the consumer must always sink res_valid.

Test Plan:
- Init: release rst_n -> busy=1 for exactly 1024 cycles, ord_ready=0 throughout, then busy=0 and ord_ready=1; an order of qty 1 to any client with max 0 -> res_accept=0, res_headroom=0.
- Basic limit: cfg client 5 max=100; orders 60, 30, 20 on consecutive cycles -> results accept/accept/reject, res_accum 60/90/90, headroom 40/10/10, each res_valid exactly 2 cycles after its handshake.
- Forwarding: max=1000 for client 7; 10 back-to-back orders of qty 50 -> all accept, final res_accum=500; next order on another client reads acc 0.
- Overflow: max=32'hFFFFFFFF, order 32'hFFFFFFF0 then 32'h20 -> first accepts, second rejects (carry), res_accum stays 32'hFFFFFFF0.
- Config collision: cfg_valid with cfg_clear_acc on client 3 in the same cycle client 3's accepted order of 40 is in S1 -> ord_ready=0 that cycle, result reports accept/40, next order of 10 reports res_accum=10.
- Reset mid-stream: assert rst_n low with two orders in flight -> res_valid never pulses for them; INIT re-runs and all accumulators read 0 afterwards.
